// File: rtl/sid_pkg.sv
// sid_pkg -- shared constants and types for the SID register file.
// Register map addresses, register-file shapes and small address classifiers
// used by sid_regs and sid_bus_latch.
package sid_pkg;

  localparam int SID_DATA_W         = 8;
  localparam int SID_ADDR_W         = 5;
  localparam int SID_NUM_REGS       = 25;  // 0x00..0x18 are storage registers
  localparam int SID_NUM_VOICE_REGS = 21;  // 0x00..0x14 are the three voices
  localparam int SID_VOICE_W        = SID_NUM_VOICE_REGS * SID_DATA_W;

  localparam logic [SID_ADDR_W-1:0] SID_FC_LO    = 5'h15;
  localparam logic [SID_ADDR_W-1:0] SID_FC_HI    = 5'h16;
  localparam logic [SID_ADDR_W-1:0] SID_RES_FILT = 5'h17;
  localparam logic [SID_ADDR_W-1:0] SID_MODE_VOL = 5'h18;
  localparam logic [SID_ADDR_W-1:0] SID_POTX     = 5'h19;
  localparam logic [SID_ADDR_W-1:0] SID_POTY     = 5'h1A;
  localparam logic [SID_ADDR_W-1:0] SID_OSC3     = 5'h1B;
  localparam logic [SID_ADDR_W-1:0] SID_ENV3     = 5'h1C;

  typedef logic [SID_NUM_VOICE_REGS-1:0][SID_DATA_W-1:0] voice_regs_t;
  typedef logic [SID_NUM_REGS-1:0][SID_DATA_W-1:0]       reg_file_t;

  // True for the four filter/volume registers that trigger filt_update.
  function automatic logic is_filt_addr(input logic [SID_ADDR_W-1:0] a);
    return (a >= SID_FC_LO) && (a <= SID_MODE_VOL);
  endfunction

  // True for addresses backed by a storage register.
  function automatic logic is_storage_addr(input logic [SID_ADDR_W-1:0] a);
    return a <= SID_MODE_VOL;
  endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// sid_bus_latch -- data bus latch of the SID.
// Captures every CPU write regardless of address; reads of write-only
// registers return this value. With SID_BUS_DECAY_EN defined, the latched
// value decays to 0x00 DECAY_TICKS ce_1m ticks after the last write.
module sid_bus_latch
  import sid_pkg::*;
#(
  parameter int DECAY_TICKS = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_1m,
  input  logic                  wr_req,
  input  logic [SID_DATA_W-1:0] data_in,
  output logic [SID_DATA_W-1:0] latch_o
);

  logic                  wr_en;
  logic [SID_DATA_W-1:0] latch_q, latch_d;

  assign wr_en = ce_1m & wr_req;

`ifdef SID_BUS_DECAY_EN
  localparam logic [15:0] DECAY_RELOAD = 16'(DECAY_TICKS);

  logic [15:0] decay_q, decay_d;

  // Reload on write; count down per tick and clear the latch on the last one.
  always_comb begin
    latch_d = latch_q;
    decay_d = decay_q;
    if (wr_en) begin
      latch_d = data_in;
      decay_d = DECAY_RELOAD;
    end else if (ce_1m && (decay_q != 16'd0)) begin
      decay_d = decay_q - 16'd1;
      if (decay_q == 16'd1) begin
        latch_d = '0;
      end
    end
  end

  // Latch and decay counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= '0;
      decay_q <= '0;
    end else begin
      latch_q <= latch_d;
      decay_q <= decay_d;
    end
  end
`else
  // Decay length is meaningless without the decay counter; fold it into a sink.
  logic unused_decay_cfg;
  assign unused_decay_cfg = ^16'(DECAY_TICKS);

  // Latch simply follows the last written value.
  always_comb begin
    latch_d = latch_q;
    if (wr_en) begin
      latch_d = data_in;
    end
  end

  // Latch state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end
`endif

  assign latch_o = latch_q;

endmodule

// File: rtl/sid_regs.sv
// sid_regs -- SID register file, CPU bus interface and sample tick generator.
// Holds registers 0x00..0x18, returns read-only sources for 0x19..0x1C and
// the bus latch for every other read, pulses filt_update after filter writes
// and sample_valid every SAMPLE_DIV ce_1m ticks.
// Optional feature: define SID_BUS_DECAY_EN to enable bus latch decay.
module sid_regs
  import sid_pkg::*;
#(
  parameter int SAMPLE_DIV  = 32,
  parameter int DECAY_TICKS = 8192
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_1m,
  input  logic                   cs,
  input  logic                   we,
  input  logic [SID_ADDR_W-1:0]  addr,
  input  logic [SID_DATA_W-1:0]  data_in,
  output logic [SID_DATA_W-1:0]  data_out,
  input  logic [SID_DATA_W-1:0]  pot_x,
  input  logic [SID_DATA_W-1:0]  pot_y,
  input  logic [SID_DATA_W-1:0]  osc3,
  input  logic [SID_DATA_W-1:0]  env3,
  output logic [SID_VOICE_W-1:0] voice_regs,
  output logic [SID_DATA_W-1:0]  Fc_lo,
  output logic [SID_DATA_W-1:0]  Fc_hi,
  output logic [SID_DATA_W-1:0]  Res_Filt,
  output logic [SID_DATA_W-1:0]  Mode_Vol,
  output logic                   filt_update,
  output logic                   sample_valid
);

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);

  logic                  wr_en, rd_en;
  logic [SID_DATA_W-1:0] bus_latch;

  reg_file_t             regs_q, regs_d;
  logic [SID_DATA_W-1:0] data_out_q, data_out_d;
  logic                  filt_update_q, filt_update_d;
  logic [7:0]            tick_q, tick_d;
  logic                  sample_valid_q, sample_valid_d;

  assign wr_en = ce_1m & cs & we;
  assign rd_en = ce_1m & cs & ~we;

  sid_bus_latch #(
    .DECAY_TICKS (DECAY_TICKS)
  ) u_bus_latch (
    .clk     (clk),
    .rst     (rst),
    .ce_1m   (ce_1m),
    .wr_req  (cs & we),
    .data_in (data_in),
    .latch_o (bus_latch)
  );

  // Register file write: only storage addresses keep the data.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && is_storage_addr(addr)) begin
      regs_d[addr] = data_in;
    end
  end

  // Read mux: read-only sources at 0x19..0x1C, the bus latch everywhere else.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      unique case (addr)
        SID_POTX: data_out_d = pot_x;
        SID_POTY: data_out_d = pot_y;
        SID_OSC3: data_out_d = osc3;
        SID_ENV3: data_out_d = env3;
        default:  data_out_d = bus_latch;
      endcase
    end
  end

  // Filter-change strobe, raised for any write to the filter block.
  always_comb begin
    filt_update_d = wr_en && is_filt_addr(addr);
  end

  // Tick divider: counts ce_1m 0..SAMPLE_DIV-1 and flags the wrap tick.
  always_comb begin
    tick_d         = tick_q;
    sample_valid_d = 1'b0;
    if (ce_1m) begin
      if (tick_q == DIV_LAST) begin
        tick_d         = 8'd0;
        sample_valid_d = 1'b1;
      end else begin
        tick_d = tick_q + 8'd1;
      end
    end
  end

  // All block state, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q         <= '0;
      data_out_q     <= '0;
      filt_update_q  <= 1'b0;
      tick_q         <= 8'd0;
      sample_valid_q <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      data_out_q     <= data_out_d;
      filt_update_q  <= filt_update_d;
      tick_q         <= tick_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign voice_regs   = regs_q[SID_NUM_VOICE_REGS-1:0];
  assign Fc_lo        = regs_q[SID_FC_LO];
  assign Fc_hi        = regs_q[SID_FC_HI];
  assign Res_Filt     = regs_q[SID_RES_FILT];
  assign Mode_Vol     = regs_q[SID_MODE_VOL];
  assign data_out     = data_out_q;
  assign filt_update  = filt_update_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sid_regs.sv
// tb_sid_regs -- randomized self-checking bench for sid_regs.
// Honors SID_BUS_DECAY_EN the same way as the design.
module tb_sid_regs;

  localparam int SAMPLE_DIV  = 4;
  localparam int DECAY_TICKS = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce_1m = 1'b0, cs = 1'b0, we = 1'b0;
  logic [4:0]   addr = '0;
  logic [7:0]   data_in = '0;
  logic [7:0]   data_out;
  logic [7:0]   pot_x = '0, pot_y = '0, osc3 = '0, env3 = '0;
  logic [167:0] voice_regs;
  logic [7:0]   Fc_lo, Fc_hi, Res_Filt, Mode_Vol;
  logic         filt_update, sample_valid;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference state.
  logic [7:0] m_regs [0:24];
  logic [7:0] m_last_wr;     // value of the most recent write
  int         m_since_wr;    // ce_1m ticks since the most recent write
  int         m_ticks;       // ce_1m ticks since reset
  logic [7:0] m_dout;
  logic       m_filt, m_sv;

  always #5 clk = ~clk;

  sid_regs #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .DECAY_TICKS (DECAY_TICKS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_1m        (ce_1m),
    .cs           (cs),
    .we           (we),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .pot_x        (pot_x),
    .pot_y        (pot_y),
    .osc3         (osc3),
    .env3         (env3),
    .voice_regs   (voice_regs),
    .Fc_lo        (Fc_lo),
    .Fc_hi        (Fc_hi),
    .Res_Filt     (Res_Filt),
    .Mode_Vol     (Mode_Vol),
    .filt_update  (filt_update),
    .sample_valid (sample_valid)
  );

  function automatic logic [7:0] m_latch();
`ifdef SID_BUS_DECAY_EN
    if (m_since_wr >= DECAY_TICKS) return 8'h00;
`endif
    return m_last_wr;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 25; i++) m_regs[i] = 8'h00;
    m_last_wr  = 8'h00;
    m_since_wr = 0;
    m_ticks    = 0;
    m_dout     = 8'h00;
    m_filt     = 1'b0;
    m_sv       = 1'b0;
  endtask

  function automatic logic [209:0] model_vec();
    logic [167:0] v;
    for (int i = 0; i < 21; i++) v[8*i +: 8] = m_regs[i];
    return {m_dout, v, m_regs[21], m_regs[22], m_regs[23], m_regs[24], m_filt, m_sv};
  endfunction

  function automatic logic [209:0] dut_vec();
    return {data_out, voice_regs, Fc_lo, Fc_hi, Res_Filt, Mode_Vol, filt_update, sample_valid};
  endfunction

  // Apply one clock of bus inputs and advance the reference model.
  task automatic cyc(input logic c, input logic s, input logic w,
                     input logic [4:0] a, input logic [7:0] d);
    logic wr, rd;
    ce_1m = c; cs = s; we = w; addr = a; data_in = d;
    @(posedge clk);
    wr = c & s & w;
    rd = c & s & ~w;
    m_filt = wr && (a >= 5'h15) && (a <= 5'h18);
    m_sv   = c && (((m_ticks + 1) % SAMPLE_DIV) == 0);
    if (rd) begin
      case (a)
        5'h19:   m_dout = pot_x;
        5'h1A:   m_dout = pot_y;
        5'h1B:   m_dout = osc3;
        5'h1C:   m_dout = env3;
        default: m_dout = m_latch();
      endcase
    end
    if (c) m_ticks++;
    if (wr) begin
      if (a <= 5'h18) m_regs[a] = d;
      m_last_wr  = d;
      m_since_wr = 0;
    end else if (c) begin
      m_since_wr++;
    end
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec++;
    if (dut_vec() !== 210'd0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_filter_write();
    cyc(1, 1, 1, 5'h17, 8'hA5);
    n_vec++;
    if (Res_Filt !== 8'hA5 || filt_update !== 1'b1) begin
      n_err++; $display("FAIL filt_write: Res_Filt=%h filt_update=%b want a5/1", Res_Filt, filt_update);
    end
    cyc(0, 0, 0, 5'h00, 8'h00);
    n_vec++;
    if (filt_update !== 1'b0) begin
      n_err++; $display("FAIL filt_pulse_width: got %b want 0", filt_update);
    end
    cyc(1, 1, 1, 5'h04, 8'h41);
    n_vec++;
    if (voice_regs[39:32] !== 8'h41 || filt_update !== 1'b0) begin
      n_err++; $display("FAIL voice_write: reg4=%h filt_update=%b want 41/0", voice_regs[39:32], filt_update);
    end
    cyc(1, 1, 1, 5'h17, 8'hA5);  // unchanged value still pulses
    n_vec++;
    if (filt_update !== 1'b1 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL filt_same_value: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_read_only();
    pot_x = 8'h3C;
    cyc(1, 1, 0, 5'h19, 8'h00);
    n_vec++;
    if (data_out !== 8'h3C) begin
      n_err++; $display("FAIL read_potx: got %h want 3c", data_out);
    end
    cyc(1, 1, 1, 5'h1B, 8'hFF);
    osc3 = 8'(($urandom % 255));  // never 0xFF
    cyc(1, 1, 0, 5'h1B, 8'h00);
    n_vec++;
    if (data_out !== osc3 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL read_osc3: got %h want %h", data_out, osc3);
    end
  endtask

  task automatic test_bus_decay();
    logic [7:0] want;
    cyc(1, 1, 1, 5'h00, 8'h5A);
    cyc(1, 1, 0, 5'h00, 8'h00);
    n_vec++;
    if (data_out !== 8'h5A) begin
      n_err++; $display("FAIL latch_read: got %h want 5a", data_out);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 5'h00, 8'h00);
    cyc(1, 1, 0, 5'h00, 8'h00);
`ifdef SID_BUS_DECAY_EN
    want = 8'h00;
`else
    want = 8'h5A;
`endif
    n_vec++;
    if (data_out !== want || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL latch_after_5_ticks: got %h want %h", data_out, want);
    end
  endtask

  task automatic test_no_effect();
    cyc(1, 1, 1, 5'h16, 8'h11);
    cyc(0, 1, 1, 5'h16, 8'hEE);
    n_vec++;
    if (Fc_hi !== 8'h11 || filt_update !== 1'b0) begin
      n_err++; $display("FAIL no_ce_write: Fc_hi=%h filt_update=%b want 11/0", Fc_hi, filt_update);
    end
    cyc(1, 0, 1, 5'h16, 8'hEE);
    n_vec++;
    if (Fc_hi !== 8'h11 || filt_update !== 1'b0) begin
      n_err++; $display("FAIL no_cs_write: Fc_hi=%h filt_update=%b want 11/0", Fc_hi, filt_update);
    end
    cyc(1, 1, 0, 5'h1D, 8'h00);
    n_vec++;
    if (data_out !== 8'h11 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL latch_untouched: got %h want 11", data_out);
    end
  endtask

  task automatic test_sample_valid();
    int last = -1;
    for (int i = 0; i < 72; i++) begin
      cyc((i % 3) == 0, $urandom_range(0, 1), 1'b1, 5'($urandom), 8'($urandom));
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL sv_cycle%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (sample_valid === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (i - last !== 12) begin
            n_err++; $display("FAIL sv_period: got %0d clk want 12", i - last);
          end
        end
        last = i;
      end
    end
    n_vec++;
    if (last < 0) begin
      n_err++; $display("FAIL sv_seen: got none want pulses");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pot_x = 8'($urandom); pot_y = 8'($urandom);
      osc3  = 8'($urandom); env3  = 8'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
          5'($urandom), 8'($urandom));
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_reset_midseq();
    for (int i = 0; i < 25; i++) cyc(1, 1, 1, 5'(i), 8'(i + 1));
    n_vec++;
    if (Mode_Vol !== 8'd25 || voice_regs[7:0] !== 8'd1) begin
      n_err++; $display("FAIL prefill: Mode_Vol=%h reg0=%h want 19/01", Mode_Vol, voice_regs[7:0]);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (dut_vec() !== 210'd0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    for (int i = 1; i <= SAMPLE_DIV; i++) begin
      cyc(1, 0, 0, 5'h00, 8'h00);
      n_vec++;
      if (sample_valid !== (i == SAMPLE_DIV)) begin
        n_err++; $display("FAIL post_reset_tick%0d: got %b want %b", i, sample_valid, i == SAMPLE_DIV);
      end
    end
    cyc(1, 1, 0, 5'h05, 8'h00);
    n_vec++;
    if (data_out !== 8'h00 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL latch_cleared: got %h want 00", data_out);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_filter_write();
    test_read_only();
    test_bus_decay();
    test_no_effect();
    test_sample_valid();
    test_random();
    test_reset_midseq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sid_regs.md
SID_REGS -- requirements
Module: sid_regs

Interface
REQ-001 Parameter SAMPLE_DIV, default 32: ce_1m ticks per sample_valid pulse, legal range 2..255.
REQ-002 Parameter DECAY_TICKS, default 8192: ce_1m ticks a written bus value persists before decaying, legal range 1..65535.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ce_1m  in  1  SID phi2 clock enable, one clk wide.
REQ-006 cs  in  1  chip select, sampled only when ce_1m=1.
REQ-007 we  in  1  1=write, 0=read.
REQ-008 addr  in  5  register address 0x00..0x1F.
REQ-009 data_in  in  8  CPU write data.
REQ-010 data_out  out  8  registered CPU read data.
REQ-011 pot_x, pot_y, osc3, env3  in  8 each  read-only sources for 0x19..0x1C.
REQ-012 voice_regs  out  168  registers 0x00..0x14 packed, register n at bits [8n+7:8n].
REQ-013 Fc_lo, Fc_hi, Res_Filt, Mode_Vol  out  8 each  registers 0x15..0x18.
REQ-014 filt_update  out  1  one-clk pulse, cycle after any write to 0x15..0x18.
REQ-015 sample_valid  out  1  one-clk pulse every SAMPLE_DIV ce_1m ticks.

Function
REQ-016 A write occurs when ce_1m & cs & we; the addressed register updates at that clk edge and is visible at outputs the next cycle.
REQ-017 Writes to 0x00..0x18 store data_in in full 8 bits; writes to 0x19..0x1F store nothing.
REQ-018 A read occurs when ce_1m & cs & !we; data_out updates at that edge and holds until the next read, one-cycle latency.
REQ-019 Read of 0x19/0x1A/0x1B/0x1C returns pot_x/pot_y/osc3/env3 sampled at the read edge.
REQ-020 Read of any other address returns the bus latch value, never the stored register.
REQ-021 Bus latch loads data_in on every write, any address including 0x19..0x1F.
REQ-022 filt_update asserts exactly one clk after a write to 0x15..0x18, including writes of unchanged values.
REQ-023 Tick counter counts ce_1m pulses 0..SAMPLE_DIV-1 and wraps; sample_valid asserts on the edge after the wrap tick, one clk wide.
REQ-024 sample_valid is independent of bus activity; a simultaneous write and wrap both take effect in the same cycle.
REQ-025 cs & we without ce_1m has no effect; cs=0 has no effect.
REQ-026 A read and a write cannot coincide (we selects one); a read in the cycle after a write to the same address returns the new latch value.

Reset
REQ-027 On rst all 25 registers, bus latch, decay counter, tick counter, data_out, filt_update, sample_valid become 0 immediately.
REQ-028 After rst deasserts, the first sample_valid follows SAMPLE_DIV ce_1m ticks.

Configuration
REQ-029 Macro SID_BUS_DECAY_EN defined: each write reloads a decay counter to DECAY_TICKS; it decrements per ce_1m; on reaching 0 the bus latch clears to 0x00 in that edge and the counter stays 0.
REQ-030 SID_BUS_DECAY_EN undefined: no decay counter exists; bus latch holds the last written value until the next write or rst.

Structure
REQ-031 Package sid_pkg holds address constants (SID_FC_LO=0x15, SID_FC_HI=0x16, SID_RES_FILT=0x17, SID_MODE_VOL=0x18, SID_POTX=0x19, SID_POTY=0x1A, SID_OSC3=0x1B, SID_ENV3=0x1C) and the voice_regs packed typedef.
REQ-032 Bus latch plus decay counter live in sub-module sid_bus_latch; all else in sid_regs.

Verification
REQ-033 Write 0x17<=0xA5 -> Res_Filt=0xA5 next cycle, filt_update one-clk pulse; write 0x04<=0x41 -> voice_regs[39:32]=0x41, no filt_update.
REQ-034 Set pot_x=0x3C, read 0x19 -> data_out=0x3C one cycle later; write 0x1B<=0xFF -> osc3 read still returns osc3 input.
REQ-035 Write 0x00<=0x5A then read 0x00 -> 0x5A; with SID_BUS_DECAY_EN, DECAY_TICKS=4, read after 5 ce_1m ticks -> 0x00; without macro -> 0x5A.
REQ-036 SAMPLE_DIV=4, ce_1m every 3 clk -> sample_valid pulses every 12 clk, one clk wide, continuing through concurrent writes.
REQ-037 Write all registers nonzero, assert rst mid-sequence -> all outputs 0 asynchronously; first sample_valid after SAMPLE_DIV ticks post-reset.
REQ-038 Write with ce_1m=0 or cs=0 -> no register, latch, or filt_update change.
